// File: rtl/proc_run_controller.sv
// Run sequencer for the 9-bit single-cycle core: start handshake, core clear,
// instruction-issue gating, run-cycle budget and completion/timeout reporting.
module proc_run_controller #(
  parameter int MAX_CYCLES   = 4096,
  parameter int CNT_W        = 16,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             done_i,
  output logic             run_en,
  output logic             core_clear,
  output logic             ack,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_e;

  localparam int                CLR_W    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_CYCLES);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CLR_W-1:0]   r_clr_cnt;
  logic [CLR_W-1:0]   w_clr_nxt;
  logic [CNT_W-1:0]   r_cycle_count;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_run_en;
  logic               r_core_clear;
  logic               r_ack;
  logic               r_timeout;

  // Next-state and counter update; illegal encodings fall back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = r_clr_cnt;
    w_cnt_nxt   = r_cycle_count;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!start) begin
          w_state_nxt = ST_CLEAR;
          w_clr_nxt   = {CLR_W{1'b0}};
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_CLEAR: begin
        if (r_clr_cnt == CLR_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_clr_nxt = r_clr_cnt + CLR_W'(1);
        end
      end
      ST_RUN: begin
        // done has priority over budget exhaustion; the done cycle is not counted
        if (done_i) begin
          w_state_nxt = ST_DONE;
        end else if (r_cycle_count == CNT_LAST) begin
          w_state_nxt = ST_TIMEOUT;
          w_cnt_nxt   = CNT_MAX;
        end else begin
          w_cnt_nxt = r_cycle_count + CNT_W'(1);
        end
      end
      ST_DONE, ST_TIMEOUT: begin
        if (start) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and output flags, all registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_clr_cnt     <= {CLR_W{1'b0}};
      r_cycle_count <= {CNT_W{1'b0}};
      r_run_en      <= 1'b0;
      r_core_clear  <= 1'b0;
      r_ack         <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_clr_cnt     <= w_clr_nxt;
      r_cycle_count <= w_cnt_nxt;
      r_run_en      <= (w_state_nxt == ST_RUN);
      r_core_clear  <= (w_state_nxt == ST_CLEAR);
      r_ack         <= (w_state_nxt == ST_DONE) || (w_state_nxt == ST_TIMEOUT);
      r_timeout     <= (w_state_nxt == ST_TIMEOUT);
    end
  end

  assign run_en      = r_run_en;
  assign core_clear  = r_core_clear;
  assign ack         = r_ack;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_count;
  assign state       = r_state;

endmodule

// File: doc/proc_run_controller.md
Name: proc_run_controller

Overview:
- Sequencing FSM for the single-cycle 9-bit-instruction processor core; replaces ad hoc start/ack glue in the top level.
- Tracks the testbench start handshake and pulses a core clear before each run.
- Gates instruction issue (NOP injection is done by the core when run_en=0), counts run cycles and enforces a cycle-budget timeout.
- Reports completion on ack.

Parameters:
MAX_CYCLES, 4096, run-cycle budget; reaching it forces TIMEOUT
CNT_W, 16, width of cycle_count; must satisfy 2^CNT_W > MAX_CYCLES
CLEAR_CYCLES, 2, number of cycles core_clear is held high before RUN (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  testbench start level; run begins on its falling edge after having been high
done_i  input  1  decoder "done" flag for the current instruction; sampled only in RUN
run_en  output  1  1 = core executes fetched instruction; 0 = core forces NOP
core_clear  output  1  clears core PC/register state; high during CLEAR
ack  output  1  run finished (DONE or TIMEOUT)
timeout  output  1  run ended by budget exhaustion
cycle_count  output  CNT_W  RUN cycles elapsed in current or last run
state  output  3  FSM state: IDLE=0, ARMED=1, CLEAR=2, RUN=3, DONE=4, TIMEOUT=5

Behaviour:
- Reset (reset=0, async): state=IDLE, clear counter=0, cycle_count=0. All 1-bit outputs are 0. Reset is honoured in any state, including mid-RUN; the run is abandoned with no ack.
- All outputs are Moore, decoded from registered state/counters; no combinational path from inputs to outputs.
- IDLE: start=1 -> ARMED.
- ARMED: waits while start=1. start=0 -> CLEAR, and on that edge clear counter=0 and cycle_count=0.
- CLEAR: core_clear=1. Clear counter increments each cycle. When the counter reaches CLEAR_CYCLES-1 -> RUN. Exactly CLEAR_CYCLES cycles with core_clear=1. start is ignored.
- RUN: run_en=1. On each rising edge, in priority order:
  - (a) done_i=1 -> DONE, cycle_count held (done cycle not counted).
  - (b) cycle_count==MAX_CYCLES-1 -> cycle_count=MAX_CYCLES, go to TIMEOUT.
  - (c) otherwise cycle_count+1, stay in RUN.
  - done wins over timeout in the same cycle. start is ignored in RUN.
- DONE: ack=1, timeout=0, cycle_count frozen. start=1 -> ARMED (new run); ack drops the cycle after.
- TIMEOUT: ack=1, timeout=1, cycle_count=MAX_CYCLES frozen. start=1 -> ARMED.
- done_i is ignored in every state except RUN.
- Glitch filtering: start 1->0 while in IDLE never launches a run; ARMED must be entered first.
- cycle_count never wraps; MAX_CYCLES bounds it.
- Illegal state encodings (6,7) -> IDLE on next clock.

Test Plan:
- Reset with reset=0 in random states, including RUN with cycle_count=37 -> immediately state=0 and all outputs 0. After release, stays IDLE with start=0.
- start high 3 cycles, then low -> ARMED for 3 cycles, then core_clear=1 for exactly 2 cycles, then run_en=1. done_i pulsed on the 10th RUN cycle -> ack=1 next cycle, timeout=0, cycle_count=9, run_en=0.
- Budget exhaustion: MAX_CYCLES=16 build, done_i held 0 -> after 16 RUN cycles, state=5, ack=1, timeout=1, cycle_count=16, held indefinitely.
- Done/timeout collision: MAX_CYCLES=16, done_i=1 on the cycle cycle_count==15 -> DONE, timeout=0, cycle_count=15.
- Ignore rules: start toggled during CLEAR/RUN, and done_i=1 in IDLE/ARMED/CLEAR -> no state change beyond the nominal sequence, and cycle_count is unaffected.
- Rerun: from DONE, start 1 then 0 -> ack falls one cycle after start rises, cycle_count resets to 0 at CLEAR entry, and the second run completes with its own count.
